fetch_unit: RTL and testbench

- Instruction-fetch front end for the pipelined MIPS core.
- Holds the program counter and the IF/ID pipeline register.
- Computes the branch and jump targets from the decoded instruction.
- Consumes the decode-stage redirect outputs, PCSrcD (= {jump, branch & EqualD}) and RegClrD (flush), and the hazard-unit stalls. It is the consumer side of the controller's PC-control interface.

---
 rtl/mips_pkg.sv | 19 +
 rtl/if_id_reg.sv | 22 ++
 rtl/fetch_unit.sv | 84 ++++++++
 tb/tb_fetch_unit.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the pipelined MIPS core.
// Imported by every pipeline stage.
package mips_pkg;

  typedef logic [31:0] addr_t;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_J   = 2'b10;

  localparam logic [31:0] NOP_INSTR = 32'h0;

  typedef struct packed {
    logic [31:0] instr;
    addr_t       pc_plus4;
    logic        valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// Enable/clear pipeline register; clears to all zeros.
// A hold (en = 0) beats a clear.
module if_id_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (en) begin
      q <= clr ? '0 : d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: PC register, next-PC select, IF/ID register,
// branch/jump target arithmetic and a saturating redirect counter.
module fetch_unit
  import mips_pkg::*;
#(
  parameter addr_t RESET_PC = 32'h0000_0000,
  parameter int    CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             StallF,
  input  logic             StallD,
  input  logic [1:0]       PCSrcD,
  input  logic             RegClrD,
  output logic [31:0]      PCF,
  input  logic [31:0]      InstrF,
  output logic [31:0]      InstrD,
  output logic [31:0]      PCPlus4D,
  output logic             ValidD,
  output logic [31:0]      PCBranchD,
  output logic [CNT_W-1:0] RedirectCnt
);

  addr_t  pc_q;
  addr_t  pc_next;
  addr_t  pc_plus4f;
  addr_t  pc_jump;
  if_id_t fd_d;
  if_id_t fd_q;
  logic   redirect;

  assign pc_plus4f = pc_q + 32'd4;
  assign PCBranchD = fd_q.pc_plus4
                   + {{14{fd_q.instr[15]}}, fd_q.instr[15:0], 2'b00};
  assign pc_jump   = {fd_q.pc_plus4[31:28], fd_q.instr[25:0], 2'b00};
  assign redirect  = (PCSrcD != PCSRC_SEQ) && !StallF;

  // Illegal 2'b11 falls into the jump arm: jump wins.
  always_comb begin
    pc_next = pc_plus4f;
    priority case (1'b1)
      PCSrcD[1]: pc_next = pc_jump;
      PCSrcD[0]: pc_next = PCBranchD;
      default:   pc_next = pc_plus4f;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_PC;
    end else if (!StallF) begin
      pc_q <= pc_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      RedirectCnt <= '0;
    end else if (redirect && (RedirectCnt != '1)) begin
      RedirectCnt <= RedirectCnt + CNT_W'(1);
    end
  end

  assign fd_d.instr    = InstrF;
  assign fd_d.pc_plus4 = pc_plus4f;
  assign fd_d.valid    = 1'b1;

  if_id_reg #(
    .W($bits(if_id_t))
  ) u_if_id (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (!StallD),
    .clr     (RegClrD),
    .d       (fd_d),
    .q       (fd_q)
  );

  assign PCF      = pc_q;
  assign InstrD   = fd_q.instr;
  assign PCPlus4D = fd_q.pc_plus4;
  assign ValidD   = fd_q.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequential fetch, branch, jump,
// stall priority, PC wrap, counter saturation and async reset.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        stall_f = 1'b0;
  logic        stall_d = 1'b0;
  logic [1:0]  pc_src = 2'b00;
  logic        reg_clr = 1'b0;
  logic [31:0] instr_f = 32'h0;
  logic [31:0] pcf;
  logic [31:0] instr_d;
  logic [31:0] pc_plus4_d;
  logic        valid_d;
  logic [31:0] pc_branch_d;
  logic [15:0] cnt;

  logic [1:0]  w_pc_src = 2'b00;
  logic        w_clr = 1'b0;
  logic [31:0] w_pcf;
  logic [31:0] w_instr_d;
  logic [31:0] w_pc_plus4_d;
  logic        w_valid_d;
  logic [31:0] w_pc_branch_d;
  logic [1:0]  w_cnt;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .StallF      (stall_f),
    .StallD      (stall_d),
    .PCSrcD      (pc_src),
    .RegClrD     (reg_clr),
    .PCF         (pcf),
    .InstrF      (instr_f),
    .InstrD      (instr_d),
    .PCPlus4D    (pc_plus4_d),
    .ValidD      (valid_d),
    .PCBranchD   (pc_branch_d),
    .RedirectCnt (cnt)
  );

  fetch_unit #(
    .RESET_PC (32'hFFFF_FFFC),
    .CNT_W    (2)
  ) u_wrap (
    .clk         (clk),
    .reset_n     (reset_n),
    .StallF      (1'b0),
    .StallD      (1'b0),
    .PCSrcD      (w_pc_src),
    .RegClrD     (w_clr),
    .PCF         (w_pcf),
    .InstrF      (32'h0),
    .InstrD      (w_instr_d),
    .PCPlus4D    (w_pc_plus4_d),
    .ValidD      (w_valid_d),
    .PCBranchD   (w_pc_branch_d),
    .RedirectCnt (w_cnt)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic [1:0] src, input logic clr);
    pc_src  = src;
    reg_clr = clr;
  endtask

  initial begin
    instr_f = 32'h2002_0005;
    #1 reset_n = 1'b0;
    #2;
    check("rst_pcf", pcf, 32'h0);
    check("rst_instr", instr_d, 32'h0);
    check("rst_pc4", pc_plus4_d, 32'h0);
    check("rst_valid", {31'b0, valid_d}, 32'h0);
    check("rst_cnt", {16'b0, cnt}, 32'h0);
    check("w_rst_pcf", w_pcf, 32'hFFFF_FFFC);
    @(negedge clk);
    reset_n = 1'b1;
    check("seq_pcf0", pcf, 32'h0);

    tick();
    check("seq_pcf1", pcf, 32'h4);
    check("w_wrap", w_pcf, 32'h0);
    tick();
    check("seq_pcf2", pcf, 32'h8);
    check("seq_instr", instr_d, 32'h2002_0005);
    check("seq_valid", {31'b0, valid_d}, 32'h1);
    check("seq_pc4", pc_plus4_d, 32'h8);
    tick();
    check("seq_pcf3", pcf, 32'hC);

    // Branch back by two words
    instr_f = 32'h1000_FFFE;
    tick();
    check("br_instr", instr_d, 32'h1000_FFFE);
    check("br_pc4", pc_plus4_d, 32'h10);
    check("br_target", pc_branch_d, 32'h8);
    redir(2'b01, 1'b1);
    instr_f = 32'hDEAD_BEEF;
    tick();
    check("br_pcf", pcf, 32'h8);
    check("br_valid", {31'b0, valid_d}, 32'h0);
    check("br_flush", instr_d, 32'h0);
    check("br_cnt", {16'b0, cnt}, 32'h1);

    // Jump to 0x0040_0004 to set up the jump test point
    redir(2'b00, 1'b0);
    instr_f = 32'h0810_0001;
    tick();
    check("bubble_fill", {31'b0, valid_d}, 32'h1);
    redir(2'b10, 1'b1);
    tick();
    check("j1_pcf", pcf, 32'h0040_0004);
    redir(2'b00, 1'b0);
    instr_f = 32'h0800_0040;
    tick();
    check("j2_pc4", pc_plus4_d, 32'h0040_0008);
    redir(2'b10, 1'b1);
    tick();
    check("j2_pcf", pcf, 32'h0000_0100);
    check("j2_flush", instr_d, 32'h0);
    check("j2_cnt", {16'b0, cnt}, 32'h3);

    // Illegal select 2'b11 takes the jump
    redir(2'b00, 1'b0);
    tick();
    check("j3_pc4", pc_plus4_d, 32'h104);
    redir(2'b11, 1'b1);
    tick();
    check("j3_pcf", pcf, 32'h100);
    check("j3_cnt", {16'b0, cnt}, 32'h4);

    // Stall beats redirect and flush
    redir(2'b00, 1'b0);
    instr_f = 32'h1000_FFFE;
    tick();
    check("st_target", pc_branch_d, 32'hFC);
    stall_f = 1'b1;
    stall_d = 1'b1;
    redir(2'b01, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("st_pcf", pcf, 32'h104);
      check("st_instr", instr_d, 32'h1000_FFFE);
      check("st_valid", {31'b0, valid_d}, 32'h1);
      check("st_cnt", {16'b0, cnt}, 32'h4);
    end
    stall_f = 1'b0;
    stall_d = 1'b0;
    tick();
    check("unst_pcf", pcf, 32'hFC);
    check("unst_valid", {31'b0, valid_d}, 32'h0);
    check("unst_cnt", {16'b0, cnt}, 32'h5);

    // Async reset between edges during a jump
    redir(2'b00, 1'b0);
    instr_f = 32'h0800_0040;
    tick();
    check("ar_pre_valid", {31'b0, valid_d}, 32'h1);
    redir(2'b10, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("ar_pcf", pcf, 32'h0);
    check("ar_valid", {31'b0, valid_d}, 32'h0);
    check("ar_instr", instr_d, 32'h0);
    check("ar_cnt", {16'b0, cnt}, 32'h0);
    check("w_ar_pcf", w_pcf, 32'hFFFF_FFFC);
    redir(2'b00, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    // Two-bit counter saturates at 3
    w_pc_src = 2'b01;
    w_clr = 1'b1;
    tick();
    check("w_cnt1", {30'b0, w_cnt}, 32'h1);
    for (int i = 0; i < 4; i++) tick();
    check("w_sat", {30'b0, w_cnt}, 32'h3);
    w_pc_src = 2'b00;
    w_clr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
